// File: rtl/csel_pkg.sv
// Shared types, defaults and stage-count helper for the pipelined carry-select adder.
package csel_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_BLOCK = 4;
    localparam int DEF_BPS   = 2;

    // Pipeline depth: blocks split into groups of bps, last group may be partial.
    function automatic int nstage(input int width, input int block, input int bps);
        if (bps <= 0 || block <= 0) begin
            return 0;
        end
        return ((width / block) + bps - 1) / bps;
    endfunction

endpackage

// File: rtl/csel_block.sv
// One carry-select block: two ripple-carry adders (carry-in 0 and 1) and an output select.
module csel_block
    import csel_pkg::*;
#(
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);

    logic [BLOCK:0]   c0;
    logic [BLOCK:0]   c1;
    logic [BLOCK-1:0] sum0;
    logic [BLOCK-1:0] sum1;

    // NOTE: every bit of c0/c1/sum0/sum1 is written on each pass, so no latch is inferred.
    always_comb begin
        c0[0] = 1'b0;
        c1[0] = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            sum0[i]  = a[i] ^ b[i] ^ c0[i];
            c0[i+1]  = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
            sum1[i]  = a[i] ^ b[i] ^ c1[i];
            c1[i+1]  = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
        end
    end

    assign sum  = cin ? sum1 : sum0;
    assign cout = cin ? c1[BLOCK] : c0[BLOCK];

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready handshake and cout/ovf/zero flags.
module pipelined_csel_adder
    import csel_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLOCK = DEF_BLOCK,
    parameter int BPS   = DEF_BPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  op_t              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NBLK   = WIDTH / BLOCK;
    localparam int NSTAGE = nstage(WIDTH, BLOCK, BPS);

    if (BPS == 0 || WIDTH % BLOCK != 0) begin : g_bad_cfg
        $fatal(1, "pipelined_csel_adder: WIDTH must be a multiple of BLOCK and BPS must be nonzero");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c_first;

    // One global enable: the whole pipe moves or the whole pipe holds.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign b_eff    = (op == OP_SUB) ? ~b : b;
    assign c_first  = (op == OP_SUB) ? 1'b1 : cin;

    for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
        localparam int LO = s * BPS;
        localparam int HI = (LO + BPS < NBLK) ? LO + BPS : NBLK;
        localparam int PW = LO * BLOCK;
        localparam int SW = HI * BLOCK;
        localparam int NW = SW - PW;
        localparam int RW = WIDTH - SW;

        logic [WIDTH-PW-1:0] a_in;
        logic [WIDTH-PW-1:0] b_in;
        logic                c_in;
        logic                v_in;
        logic [NW-1:0]       sum_new;
        logic                c_out;
        logic [SW-1:0]       sum_d;
        logic                v_q;
        logic                c_q;
        logic [SW-1:0]       sum_q;

        if (s == 0) begin : g_first
            assign a_in  = a;
            assign b_in  = b_eff;
            assign c_in  = c_first;
            assign v_in  = in_valid;
            assign sum_d = sum_new;
        end else begin : g_next
            assign a_in  = g_stage[s-1].g_skew.a_q;
            assign b_in  = g_stage[s-1].g_skew.b_q;
            assign c_in  = g_stage[s-1].c_q;
            assign v_in  = g_stage[s-1].v_q;
            assign sum_d = {sum_new, g_stage[s-1].sum_q};
        end

        for (genvar k = 0; k < HI - LO; k++) begin : g_blk
            logic c_i;
            logic c_o;
            if (k == 0) begin : g_c_head
                assign c_i = c_in;
            end else begin : g_c_chain
                assign c_i = g_blk[k-1].c_o;
            end
            csel_block #(.BLOCK(BLOCK)) u_blk (
                .a    (a_in[k*BLOCK +: BLOCK]),
                .b    (b_in[k*BLOCK +: BLOCK]),
                .cin  (c_i),
                .sum  (sum_new[k*BLOCK +: BLOCK]),
                .cout (c_o)
            );
        end
        assign c_out = g_blk[HI-LO-1].c_o;

        // NOTE: datapath registers are reset too, so sum and flags read 0 straight out of reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                v_q   <= v_in;
                c_q   <= c_out;
                sum_q <= sum_d;
            end
        end

        if (s < NSTAGE - 1) begin : g_skew
            // Unconsumed upper operand slices; their MSBs carry the sign bits forward.
            logic [RW-1:0] a_q;
            logic [RW-1:0] b_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[WIDTH-PW-1 -: RW];
                    b_q <= b_in[WIDTH-PW-1 -: RW];
                end
            end
        end else begin : g_flags
            logic ovf_q;
            logic zero_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    ovf_q  <= (a_in[WIDTH-PW-1] == b_in[WIDTH-PW-1]) &&
                              (sum_new[NW-1] != a_in[WIDTH-PW-1]);
                    zero_q <= ~|sum_d;
                end
            end
        end
    end

    assign out_valid = g_stage[NSTAGE-1].v_q;
    assign sum       = g_stage[NSTAGE-1].sum_q;
    assign cout      = g_stage[NSTAGE-1].c_q;
    assign ovf       = g_stage[NSTAGE-1].g_flags.ovf_q;
    assign zero      = g_stage[NSTAGE-1].g_flags.zero_q;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Bench for pipelined_csel_adder: three configurations driven in lockstep, each scored against an arithmetic model.
module tb_pipelined_csel_adder;
    import csel_pkg::*;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        op_t         op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        res_t        exp;
    } dir_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        cin;
    logic        out_ready;
    op_t         op;
    logic [63:0] a64;
    logic [63:0] b64;

    logic        in_ready0, out_valid0, cout0, ovf0, zero0;
    logic        in_ready1, out_valid1, cout1, ovf1, zero1;
    logic        in_ready2, out_valid2, cout2, ovf2, zero2;
    logic [31:0] sum0;
    logic [15:0] sum1;
    logic [63:0] sum2;

    always #5 clk = ~clk;

    pipelined_csel_adder #(.WIDTH(32), .BLOCK(4), .BPS(2)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a64[31:0]), .b(b64[31:0]), .cin(cin), .op(op),
        .out_valid(out_valid0), .out_ready(out_ready),
        .sum(sum0), .cout(cout0), .ovf(ovf0), .zero(zero0)
    );

    pipelined_csel_adder #(.WIDTH(16), .BLOCK(4), .BPS(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a64[15:0]), .b(b64[15:0]), .cin(cin), .op(op),
        .out_valid(out_valid1), .out_ready(out_ready),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1)
    );

    pipelined_csel_adder #(.WIDTH(64), .BLOCK(8), .BPS(3)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a64), .b(b64), .cin(cin), .op(op),
        .out_valid(out_valid2), .out_ready(out_ready),
        .sum(sum2), .cout(cout2), .ovf(ovf2), .zero(zero2)
    );

    logic [2:0] in_ready_v;
    logic [2:0] out_valid_v;
    res_t       obs [3];

    assign in_ready_v  = {in_ready2, in_ready1, in_ready0};
    assign out_valid_v = {out_valid2, out_valid1, out_valid0};
    assign obs[0] = {32'h0, sum0, cout0, ovf0, zero0};
    assign obs[1] = {48'h0, sum1, cout1, ovf1, zero1};
    assign obs[2] = {sum2, cout2, ovf2, zero2};

    int   n_cmp = 0;
    int   n_err = 0;
    res_t exp_mem [3][256];
    int   wr_ptr [3];
    int   rd_ptr [3];
    int   accepted [3];
    int   retired [3];

    function automatic int width_of(input int d);
        case (d)
            0:       return 32;
            1:       return 16;
            default: return 64;
        endcase
    endfunction

    function automatic int nstage_of(input int d);
        return (d == 2) ? 3 : 4;
    endfunction

    // Reference: plain integer add/subtract, signed overflow judged by range.
    function automatic res_t model(input int w, input op_t o, input logic [63:0] x,
                                   input logic [63:0] y, input logic ci);
        logic [63:0]        mask;
        logic [65:0]        ux, uy, u;
        logic signed [66:0] sx, sy, sr, lim;
        res_t               r;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        ux   = {2'b00, x & mask};
        uy   = {2'b00, y & mask};
        sx   = 67'(ux);
        sy   = 67'(uy);
        if (x[w-1]) sx = sx - (67'sd1 <<< w);
        if (y[w-1]) sy = sy - (67'sd1 <<< w);
        lim  = 67'sd1 <<< (w - 1);
        if (o == OP_ADD) begin
            u      = ux + uy + 66'(ci);
            sr     = sx + sy + 67'(ci);
            r.cout = u[w];
        end else begin
            u      = ux - uy;
            sr     = sx - sy;
            r.cout = (ux >= uy);
        end
        r.sum  = u[63:0] & mask;
        r.ovf  = (sr >= lim) || (sr < -lim);
        r.zero = (r.sum == 64'h0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [66:0] observed, input logic [66:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic reset_sb();
        for (int d = 0; d < 3; d++) begin
            wr_ptr[d]   = 0;
            rd_ptr[d]   = 0;
            accepted[d] = 0;
            retired[d]  = 0;
        end
    endtask

    // Called just after a negedge with inputs set: scores this cycle, then advances one clock.
    task automatic tick();
        #1;
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                if (out_valid_v[d] && out_ready) begin
                    check($sformatf("sb_nonempty_d%0d", d), 67'(wr_ptr[d] != rd_ptr[d]), 67'(1));
                    if (wr_ptr[d] != rd_ptr[d]) begin
                        check($sformatf("result_d%0d_beat%0d", d, retired[d]),
                              obs[d], exp_mem[d][rd_ptr[d] % 256]);
                        rd_ptr[d]++;
                    end
                    retired[d]++;
                end
                if (in_valid && in_ready_v[d]) begin
                    exp_mem[d][wr_ptr[d] % 256] = model(width_of(d), op, a64, b64, cin);
                    wr_ptr[d]++;
                    accepted[d]++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_beat();
        op  = op_t'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
        a64 = {$urandom, $urandom};
        b64 = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       b64 = a64;
            1:       a64 = '1;
            2:       b64 = 64'h1;
            default: ;
        endcase
    endtask

    dir_t dirs [6] = '{
        '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0, '{64'h00000000, 1'b1, 1'b0, 1'b1}},
        '{OP_ADD, 32'h00000000, 32'h00000000, 1'b1, '{64'h00000001, 1'b0, 1'b0, 1'b0}},
        '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, '{64'h80000000, 1'b0, 1'b1, 1'b0}},
        '{OP_SUB, 32'h00000005, 32'h00000007, 1'b1, '{64'hFFFFFFFE, 1'b0, 1'b0, 1'b0}},
        '{OP_SUB, 32'h80000000, 32'h00000001, 1'b0, '{64'h7FFFFFFF, 1'b1, 1'b1, 1'b0}},
        '{OP_SUB, 32'h12345678, 32'h12345678, 1'b0, '{64'h00000000, 1'b1, 1'b0, 1'b1}}
    };

    initial begin
        int   lat [3];
        int   cyc;
        int   base;
        int   guard;
        res_t snap;

        rst = 1'b1; in_valid = 1'b0; cin = 1'b0; op = OP_ADD;
        a64 = '0; b64 = '0; out_ready = 1'b1;
        reset_sb();
        @(negedge clk);

        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_outputs_d%0d", d), obs[d], 67'(0));
            check($sformatf("reset_handshake_d%0d", d), 67'({in_ready_v[d], out_valid_v[d]}), 67'(2'b10));
        end
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Directed corner cases: exact values on the default config, latency on all three.
        for (int i = 0; i < 6; i++) begin
            op = dirs[i].op; cin = dirs[i].cin;
            a64 = {32'h0, dirs[i].a}; b64 = {32'h0, dirs[i].b};
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            lat = '{0, 0, 0};
            cyc = 1;
            while (cyc < 12) begin
                for (int d = 0; d < 3; d++) begin
                    if (lat[d] == 0 && out_valid_v[d]) begin
                        lat[d] = cyc;
                        if (d == 0) check($sformatf("directed_%0d", i), obs[0], dirs[i].exp);
                    end
                end
                if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
                tick();
                cyc++;
            end
            for (int d = 0; d < 3; d++)
                check($sformatf("latency_dir%0d_d%0d", i, d), 67'(lat[d]), 67'(nstage_of(d)));
            tick();
        end

        // Back-to-back streaming with no backpressure.
        base = accepted[0];
        cyc  = retired[0];
        for (int i = 0; i < 200; i++) begin
            rand_beat();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("stream_accepted_d0", 67'(accepted[0] - base), 67'(200));
        check("stream_retired_d0", 67'(retired[0] - cyc), 67'(200));

        // Fill, stall three cycles, then drain.
        for (int i = 0; i < 6; i++) begin
            rand_beat();
            in_valid = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        snap = '0;
        for (int k = 0; k < 3; k++) begin
            rand_beat();
            #1;
            check($sformatf("stall_in_ready_%0d", k), 67'(in_ready_v), 67'(0));
            check($sformatf("stall_out_valid_%0d", k), 67'(out_valid_v), 67'(3'b111));
            if (k == 0) snap = obs[0];
            else check($sformatf("stall_stable_%0d", k), obs[0], snap);
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        for (int d = 0; d < 3; d++)
            check($sformatf("stall_drain_d%0d", d), 67'(accepted[d] - retired[d]), 67'(0));

        // Random valid and ready toggling until 500 beats enter the default config.
        base  = accepted[0];
        guard = 0;
        while (accepted[0] - base < 500 && guard < 4000) begin
            rand_beat();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            guard++;
        end
        check("toggle_beats_d0", 67'(accepted[0] - base), 67'(500));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        for (int d = 0; d < 3; d++)
            check($sformatf("toggle_drain_d%0d", d), 67'(accepted[d] - retired[d]), 67'(0));

        // Reset with the pipes full and stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_beat();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("prereset_valid", 67'(out_valid_v), 67'(3'b111));
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("midreset_outputs_d%0d", d), obs[d], 67'(0));
            check($sformatf("midreset_handshake_d%0d", d), 67'({in_ready_v[d], out_valid_v[d]}), 67'(2'b10));
        end
        reset_sb();
        tick();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        for (int d = 0; d < 3; d++)
            check($sformatf("postreset_no_stale_d%0d", d), 67'(retired[d]), 67'(0));
        for (int i = 0; i < 12; i++) begin
            rand_beat();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        for (int d = 0; d < 3; d++)
            check($sformatf("postreset_beats_d%0d", d), 67'(retired[d]), 67'(12));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
